// File: rtl/apb_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: setup/enable sequencing, AHB stall.
// Define APB_PREADY_EN to honour PREADY wait states; otherwise every enable is one cycle.
module apb_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              Valid,
  input  logic              HWRITE,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic [NSEL-1:0]   temp_SELX,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  output logic [NSEL-1:0]   PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              HREADYout,
  output logic [DATA_W-1:0] HRDATA
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RENABLE = 3'd4,
    ST_WENABLE = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] addr_r;
  logic [NSEL-1:0]   sel_r;
  logic [DATA_W-1:0] wdata_r;
  logic              dir_r;

  logic ready;
  logic in_enable;
  logic accept;

`ifdef APB_PREADY_EN
  assign ready = PREADY;
`else
  logic unused_pready;
  assign ready         = 1'b1;
  assign unused_pready = PREADY;
`endif

  assign in_enable = (state_q == ST_RENABLE) ||
                     (state_q == ST_WENABLE);

  // New transfers launch from idle or from a completing enable cycle.
  assign accept = Valid &&
                  ((state_q == ST_IDLE) || (in_enable && ready));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = HWRITE ? ST_WWAIT : ST_READ;
        end
      end
      ST_WWAIT: state_d = ST_WRITE;
      ST_READ:  state_d = ST_RENABLE;
      ST_WRITE: state_d = ST_WENABLE;
      ST_RENABLE, ST_WENABLE: begin
        if (accept) begin
          state_d = HWRITE ? ST_WWAIT : ST_READ;
        end else if (ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_r  <= '0;
      sel_r   <= '0;
      dir_r   <= 1'b0;
      wdata_r <= '0;
    end else begin
      if (accept) begin
        addr_r <= HADDR;
        sel_r  <= temp_SELX;
        dir_r  <= HWRITE;
      end
      // Write data arrives one cycle behind its address phase.
      if (state_q == ST_WWAIT) begin
        wdata_r <= HWDATA;
      end
    end
  end

  always_comb begin
    PSEL      = '0;
    PENABLE   = 1'b0;
    HREADYout = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        HREADYout = 1'b1;
      end
      ST_WWAIT: begin
        HREADYout = 1'b0;
      end
      ST_READ, ST_WRITE: begin
        PSEL      = sel_r;
        HREADYout = 1'b0;
      end
      ST_RENABLE, ST_WENABLE: begin
        PSEL      = sel_r;
        PENABLE   = 1'b1;
        HREADYout = ready;
      end
      default: begin
        HREADYout = 1'b1;
      end
    endcase
  end

  assign PADDR  = addr_r;
  assign PWRITE = dir_r;
  assign PWDATA = wdata_r;
  assign HRDATA = PRDATA;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: reset, read, write, back-to-back,
// ignored request, select passthrough, mid-transfer reset and wait states.
module tb_apb_controller;

  logic        HCLK;
  logic        HRESETn;
  logic        Valid;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  temp_SELX;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        HREADYout;
  logic [31:0] HRDATA;

  int n_tests;
  int n_fail;

  apb_controller #(
    .ADDR_W(32),
    .DATA_W(32),
    .NSEL(3)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .Valid(Valid),
    .HWRITE(HWRITE),
    .HADDR(HADDR),
    .HWDATA(HWDATA),
    .temp_SELX(temp_SELX),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .HREADYout(HREADYout),
    .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input logic wr,
                     input logic [31:0] a,
                     input logic [2:0] s);
    Valid     = 1'b1;
    HWRITE    = wr;
    HADDR     = a;
    temp_SELX = s;
  endtask

  task automatic idle_in();
    Valid     = 1'b0;
    HWRITE    = 1'b0;
    HADDR     = 32'h0;
    temp_SELX = 3'b000;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    HRESETn = 1'b0;
    PREADY  = 1'b1;
    HWDATA  = 32'h0;
    PRDATA  = 32'h0;
    idle_in();
    tick();
    tick();

    // reset state
    check("rst_psel", {29'd0, PSEL}, 32'd0);
    check("rst_penable", {31'd0, PENABLE}, 32'd0);
    check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_hready", {31'd0, HREADYout}, 32'd1);
    HRESETn = 1'b1;
    tick();
    check("idle_hready", {31'd0, HREADYout}, 32'd1);

    // single read
    req(1'b0, 32'h8000_0010, 3'b001);
    PRDATA = 32'hCAFE_F00D;
    tick();
    idle_in();
    check("rd_setup_psel", {29'd0, PSEL}, 32'd1);
    check("rd_setup_pen", {31'd0, PENABLE}, 32'd0);
    check("rd_setup_paddr", PADDR, 32'h8000_0010);
    check("rd_setup_pwrite", {31'd0, PWRITE}, 32'd0);
    check("rd_setup_hready", {31'd0, HREADYout}, 32'd0);
    // PREADY low must not stall the default build
`ifndef APB_PREADY_EN
    PREADY = 1'b0;
`endif
    tick();
    check("rd_en_pen", {31'd0, PENABLE}, 32'd1);
    check("rd_en_psel", {29'd0, PSEL}, 32'd1);
    check("rd_en_hready", {31'd0, HREADYout}, 32'd1);
    check("rd_en_hrdata", HRDATA, 32'hCAFE_F00D);
    PREADY = 1'b1;
    tick();
    check("rd_done_psel", {29'd0, PSEL}, 32'd0);
    check("rd_done_hready", {31'd0, HREADYout}, 32'd1);

    // single write
    req(1'b1, 32'h8800_0004, 3'b010);
    tick();
    idle_in();
    HWDATA = 32'h1234_5678;
    check("wr_wait_hready", {31'd0, HREADYout}, 32'd0);
    check("wr_wait_psel", {29'd0, PSEL}, 32'd0);
    check("wr_wait_pen", {31'd0, PENABLE}, 32'd0);
    tick();
    HWDATA = 32'h0;
    check("wr_setup_psel", {29'd0, PSEL}, 32'd2);
    check("wr_setup_pwrite", {31'd0, PWRITE}, 32'd1);
    check("wr_setup_pwdata", PWDATA, 32'h1234_5678);
    check("wr_setup_paddr", PADDR, 32'h8800_0004);
    check("wr_setup_pen", {31'd0, PENABLE}, 32'd0);
    check("wr_setup_hready", {31'd0, HREADYout}, 32'd0);
    tick();
    check("wr_en_pen", {31'd0, PENABLE}, 32'd1);
    check("wr_en_hready", {31'd0, HREADYout}, 32'd1);
    check("wr_en_pwdata", PWDATA, 32'h1234_5678);
    tick();
    check("wr_done_psel", {29'd0, PSEL}, 32'd0);

    // back-to-back write then read
    req(1'b1, 32'h8400_0000, 3'b100);
    tick();
    idle_in();
    HWDATA = 32'hAAAA_5555;
    tick();
    HWDATA = 32'h0;
    tick();
    check("b2b_wen_pen", {31'd0, PENABLE}, 32'd1);
    check("b2b_wen_pwrite", {31'd0, PWRITE}, 32'd1);
    req(1'b0, 32'h8400_0008, 3'b001);
    PRDATA = 32'h5A5A_0001;
    tick();
    idle_in();
    check("b2b_rd_psel", {29'd0, PSEL}, 32'd1);
    check("b2b_rd_pen", {31'd0, PENABLE}, 32'd0);
    check("b2b_rd_paddr", PADDR, 32'h8400_0008);
    check("b2b_rd_pwrite", {31'd0, PWRITE}, 32'd0);
    tick();
    check("b2b_rd_hrdata", HRDATA, 32'h5A5A_0001);
    check("b2b_rd_hready", {31'd0, HREADYout}, 32'd1);
    tick();

    // request ignored while in setup
    req(1'b0, 32'h8000_0020, 3'b010);
    tick();
    req(1'b1, 32'h9999_0000, 3'b100);
    tick();
    idle_in();
    check("ign_paddr", PADDR, 32'h8000_0020);
    check("ign_psel", {29'd0, PSEL}, 32'd2);
    check("ign_pwrite", {31'd0, PWRITE}, 32'd0);
    check("ign_pen", {31'd0, PENABLE}, 32'd1);
    tick();
    check("ign_idle_psel", {29'd0, PSEL}, 32'd0);

    // non-one-hot select passes through
    req(1'b0, 32'h8000_00F0, 3'b011);
    tick();
    idle_in();
    check("sel_pass", {29'd0, PSEL}, 32'd3);
    tick();
    tick();

    // reset during write enable
    req(1'b1, 32'h8C00_0000, 3'b001);
    tick();
    idle_in();
    HWDATA = 32'h0F0F_0F0F;
    tick();
    tick();
    check("mrst_wen_pen", {31'd0, PENABLE}, 32'd1);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    check("mrst_psel", {29'd0, PSEL}, 32'd0);
    check("mrst_pen", {31'd0, PENABLE}, 32'd0);
    check("mrst_hready", {31'd0, HREADYout}, 32'd1);
    check("mrst_paddr", PADDR, 32'h0);
    check("mrst_pwdata", PWDATA, 32'h0);
    req(1'b0, 32'h8000_0030, 3'b100);
    PRDATA = 32'h1111_2222;
    tick();
    idle_in();
    check("mrst_rd_psel", {29'd0, PSEL}, 32'd4);
    check("mrst_rd_paddr", PADDR, 32'h8000_0030);
    tick();
    check("mrst_rd_hready", {31'd0, HREADYout}, 32'd1);
    check("mrst_rd_hrdata", HRDATA, 32'h1111_2222);
    tick();

`ifdef APB_PREADY_EN
    // wait states on a read enable
    req(1'b0, 32'h8000_0040, 3'b001);
    PRDATA = 32'hBEEF_0042;
    tick();
    idle_in();
    PREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_pen", {31'd0, PENABLE}, 32'd1);
      check("ws_paddr", PADDR, 32'h8000_0040);
      check("ws_hready", {31'd0, HREADYout}, 32'd0);
    end
    tick();
    PREADY = 1'b1;
    #1;
    check("ws_last_pen", {31'd0, PENABLE}, 32'd1);
    check("ws_last_paddr", PADDR, 32'h8000_0040);
    check("ws_last_hready", {31'd0, HREADYout}, 32'd1);
    check("ws_hrdata", HRDATA, 32'hBEEF_0042);
    tick();
    check("ws_done_psel", {29'd0, PSEL}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_controller.md
Name: apb_controller

Overview:
- APB-side sequencer of the AHB-to-APB bridge; sits downstream of the AHB slave interface.
- Consumes the slave's Valid, select and address/data/direction signals.
- Drives the APB setup/enable protocol (PSEL/PENABLE/PWRITE/PADDR/PWDATA) toward up to three peripherals.
- Returns HREADYout/HRDATA to the AHB side, stalling the AHB master while an APB transfer is in flight.

Parameters:
- ADDR_W, 32, width of HADDR/PADDR
- DATA_W, 32, width of HWDATA/PWDATA/PRDATA/HRDATA
- NSEL, 3, number of one-hot peripheral selects

Ports:
- HCLK  in  1  bridge clock; all state changes on rising edge
- HRESETn  in  1  synchronous active-low reset, sampled on HCLK rising edge
- Valid  in  1  AHB transfer request for the bridge address range (from AHB slave interface)
- HWRITE  in  1  direction of the current AHB address phase (1 = write)
- HADDR  in  ADDR_W  current AHB address-phase address
- HWDATA  in  DATA_W  AHB write data (data phase)
- temp_SELX  in  NSEL  one-hot peripheral select decoded from HADDR
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB wait-state input (used only with APB_PREADY_EN)
- PSEL  out  NSEL  APB peripheral select, one-hot
- PENABLE  out  1  APB enable phase
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- HREADYout  out  1  AHB ready back to the master
- HRDATA  out  DATA_W  AHB read data

Behaviour:
- State encoding:
  - States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_RENABLE, ST_WENABLE.
  - Held in a state register; outputs are decoded from the state and internal capture registers addr_r, sel_r, wdata_r, dir_r.
- Reset (HRESETn = 0 at a rising edge):
  - Next state is ST_IDLE.
  - addr_r, sel_r, wdata_r and dir_r are cleared to 0.
  - Outputs: PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, HREADYout = 1.
  - Reset mid-transfer aborts the transfer; PSEL and PENABLE drop in the cycle after the reset edge.
- Acceptance point:
  - A transfer is accepted when Valid = 1 in ST_IDLE, or in a completing enable cycle.
  - On acceptance: addr_r <= HADDR, sel_r <= temp_SELX, dir_r <= HWRITE.
  - Valid in any other state is ignored; the master is stalled there by HREADYout = 0.
- Transitions:
  - ST_IDLE: Valid & !HWRITE -> ST_READ; Valid & HWRITE -> ST_WWAIT; otherwise stay.
  - ST_WWAIT: capture wdata_r <= HWDATA -> ST_WRITE.
  - ST_READ -> ST_RENABLE; ST_WRITE -> ST_WENABLE.
  - ST_RENABLE / ST_WENABLE, when complete (ready = 1): next state is chosen exactly as from ST_IDLE (back-to-back transfers allowed).
  - ST_RENABLE / ST_WENABLE, when ready = 0: stay.
- Output decode per state:
  - ST_IDLE: PSEL = 0, PENABLE = 0, HREADYout = 1.
  - ST_WWAIT: PSEL = 0, PENABLE = 0, HREADYout = 0. The master holds HWDATA during the stalled data phase.
  - ST_READ / ST_WRITE (setup): PSEL = sel_r, PENABLE = 0, PWRITE = dir_r, PADDR = addr_r, PWDATA = wdata_r, HREADYout = 0.
  - ST_RENABLE / ST_WENABLE: same as setup except PENABLE = 1, and HREADYout = ready.
- HRDATA = PRDATA combinationally; it is meaningful only in ST_RENABLE while HREADYout = 1.
- PADDR, PWRITE, PWDATA and PSEL hold stable from the setup cycle through the final enable cycle.
- Latency:
  - Read: setup in the cycle after acceptance; HREADYout = 1 two cycles after acceptance (zero wait).
  - Write: setup in the second cycle after acceptance; completion three cycles after acceptance.
- Select: temp_SELX = 0 or non-one-hot is passed through unchanged. Validity is the upstream decoder's responsibility.

Optional Feature:
- APB_PREADY_EN defined:
  - ready = PREADY.
  - Enable states extend while PREADY = 0 (HREADYout = 0, all APB outputs held).
- APB_PREADY_EN undefined:
  - ready = 1; PREADY port is present but ignored.
  - Every enable phase lasts exactly one cycle.

Test Plan:
- Reset mid-transfer:
  - Stimulus: HRESETn = 0 during ST_WENABLE.
  - Response: next cycle PSEL = 0, PENABLE = 0, HREADYout = 1, PADDR = 0; the FSM then accepts a fresh read normally.
- Single read:
  - Stimulus: Valid = 1, HWRITE = 0, HADDR = 32'h8000_0010, temp_SELX = 3'b001, PRDATA = 32'hCAFE_F00D.
  - Response: setup cycle PSEL = 001, PENABLE = 0, PADDR = 32'h8000_0010; next cycle PENABLE = 1, HREADYout = 1, HRDATA = 32'hCAFE_F00D.
- Single write:
  - Stimulus: Valid = 1, HWRITE = 1, HADDR = 32'h8800_0004, temp_SELX = 3'b010; HWDATA = 32'h1234_5678 in the following cycle.
  - Response: ST_WWAIT with HREADYout = 0; setup PSEL = 010, PWRITE = 1, PWDATA = 32'h1234_5678; enable next cycle, HREADYout = 1.
- Back-to-back write then read:
  - Stimulus: write to 32'h8400_0000, then Valid = 1, HWRITE = 0 presented in the WENABLE cycle.
  - Response: the read setup begins in the very next cycle with no ST_IDLE in between.
- Ignored request:
  - Stimulus: Valid pulsed while in ST_READ.
  - Response: no new capture; addr_r is unchanged and the transfer completes with the original address.
- Wait states (APB_PREADY_EN):
  - Stimulus: PREADY = 0 for 3 cycles during ST_RENABLE.
  - Response: PENABLE = 1 and PADDR stable for 4 cycles; HREADYout = 0 for 3 cycles, then 1 with HRDATA = PRDATA.
